// File: rtl/donkey_move_ctl.sv
// Donkey sprite motion sequencer: button-driven horizontal steps, a
// grounded/rising/falling jump machine and platform following.
module donkey_move_ctl #(
    parameter int INITIAL_XPOS    = 128,
    parameter int INITIAL_YPOS    = 672,
    parameter int CHARACTER_WIDTH = 48,
    parameter int JUMP_HEIGHT     = 61,
    parameter int JUMP_STEP_CLKS  = 1_400_000,
    parameter int MOVE_STEP_CLKS  = 250_000,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic [11:0] ground_ypos,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        facing_left,
    output logic        airborne
);

    localparam int MW = (MOVE_STEP_CLKS > 1) ? $clog2(MOVE_STEP_CLKS) : 1;
    localparam int JW = (JUMP_STEP_CLKS > 1) ? $clog2(JUMP_STEP_CLKS) : 1;
    localparam int HW = (JUMP_HEIGHT > 0) ? $clog2(JUMP_HEIGHT + 1) : 1;
    localparam logic [MW-1:0] MOVE_LAST   = MW'(MOVE_STEP_CLKS - 1);
    localparam logic [JW-1:0] JUMP_LAST   = JW'(JUMP_STEP_CLKS - 1);
    localparam logic [HW-1:0] HEIGHT_LAST = HW'(JUMP_HEIGHT - 1);
    localparam logic [11:0]   X_LO        = 12'(X_MIN);
    localparam logic [11:0]   X_HI        = 12'(X_MAX - CHARACTER_WIDTH);

    typedef enum logic [1:0] {
        ST_GROUNDED,
        ST_RISING,
        ST_FALLING
    } state_t;

    state_t        r_state;
    logic [11:0]   r_xpos;
    logic [11:0]   r_ypos;
    logic          r_facing_left;
    logic          r_airborne;
    logic [MW-1:0] r_move_cnt;
    logic [JW-1:0] r_jump_cnt;
    logic [HW-1:0] r_height;
    logic          r_jump_q;

    logic w_jump_edge;
    logic w_move_tick;
    logic w_jump_tick;
    logic w_fall_land;

    assign w_jump_edge = btn_jump & ~r_jump_q;
    assign w_move_tick = en && (r_move_cnt == MOVE_LAST);
    assign w_jump_tick = en && (r_state != ST_GROUNDED) && (r_jump_cnt == JUMP_LAST);
    // Widened by one bit so a sprite at 4095 cannot wrap past the ground.
    assign w_fall_land = ({1'b0, r_ypos} + 13'd1) >= {1'b0, ground_ypos};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_GROUNDED;
            r_xpos        <= 12'(INITIAL_XPOS);
            r_ypos        <= 12'(INITIAL_YPOS);
            r_facing_left <= 1'b0;
            r_airborne    <= 1'b0;
            r_move_cnt    <= '0;
            r_jump_cnt    <= '0;
            r_height      <= '0;
            r_jump_q      <= 1'b0;
        end else begin
            r_jump_q <= btn_jump;
            if (en) begin
                r_move_cnt <= w_move_tick ? '0 : r_move_cnt + 1'b1;
                if (w_move_tick) begin
                    if (btn_left && !btn_right) begin
                        r_facing_left <= 1'b1;
                        if (r_xpos > X_LO) r_xpos <= r_xpos - 1'b1;
                    end else if (btn_right && !btn_left) begin
                        r_facing_left <= 1'b0;
                        if (r_xpos < X_HI) r_xpos <= r_xpos + 1'b1;
                    end
                end

                case (r_state)
                    ST_GROUNDED: begin
                        if (w_jump_edge) begin
                            r_state    <= ST_RISING;
                            r_airborne <= 1'b1;
                            r_height   <= '0;
                            r_jump_cnt <= '0;
                        end else if (ground_ypos > r_ypos) begin
                            r_state    <= ST_FALLING;
                            r_airborne <= 1'b1;
                            r_jump_cnt <= '0;
                        end else if (ground_ypos < r_ypos) begin
                            r_ypos <= ground_ypos;
                        end
                    end
                    ST_RISING: begin
                        // The counter wraps to 0 on the tick, so a tick-driven
                        // switch to FALLING starts that phase from a clean count.
                        r_jump_cnt <= w_jump_tick ? '0 : r_jump_cnt + 1'b1;
                        if (w_jump_tick) begin
                            if (r_ypos == 12'd0) begin
                                r_state <= ST_FALLING;
                            end else begin
                                r_ypos   <= r_ypos - 1'b1;
                                r_height <= r_height + 1'b1;
                                if (r_height == HEIGHT_LAST) r_state <= ST_FALLING;
                            end
                        end
                    end
                    ST_FALLING: begin
                        if (ground_ypos <= r_ypos) begin
                            r_ypos     <= ground_ypos;
                            r_state    <= ST_GROUNDED;
                            r_airborne <= 1'b0;
                        end else begin
                            r_jump_cnt <= w_jump_tick ? '0 : r_jump_cnt + 1'b1;
                            if (w_jump_tick) begin
                                if (w_fall_land) begin
                                    r_ypos     <= ground_ypos;
                                    r_state    <= ST_GROUNDED;
                                    r_airborne <= 1'b0;
                                end else begin
                                    r_ypos <= r_ypos + 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        r_state    <= ST_GROUNDED;
                        r_airborne <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign xpos        = r_xpos;
    assign ypos        = r_ypos;
    assign facing_left = r_facing_left;
    assign airborne    = r_airborne;

endmodule

// File: tb/tb_donkey_move_ctl.sv
// Bench for donkey_move_ctl: hand-computed vector table, corner sequences,
// and random stimulus checked every cycle against a behavioural model.
module tb_donkey_move_ctl;

    localparam int MOVE  = 4;
    localparam int JSTEP = 2;
    localparam int JH    = 5;
    localparam int XMAX  = 180;
    localparam int CW    = 48;
    localparam int XMIN  = 0;
    localparam int M_GROUND = 0;
    localparam int M_RISE   = 1;
    localparam int M_FALL   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [11:0] ground_ypos = 12'd672;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        facing_left;
    logic        airborne;

    int n_total = 0;
    int n_bad = 0;

    // Reference model: counts enabled cycles and airborne cycles directly.
    int m_x, m_y, m_face, m_mode, m_en_cyc, m_air_cyc, m_climb;
    bit m_prev_j;

    typedef struct {
        bit en; bit l; bit r; bit j; int g; int n;
        int ex; int ey; int ef; int ea;
    } vec_t;
    vec_t vecs[$];

    donkey_move_ctl #(
        .MOVE_STEP_CLKS(MOVE), .JUMP_STEP_CLKS(JSTEP), .JUMP_HEIGHT(JH),
        .X_MAX(XMAX), .CHARACTER_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .btn_left(btn_left),
        .btn_right(btn_right), .btn_jump(btn_jump), .ground_ypos(ground_ypos),
        .xpos(xpos), .ypos(ypos), .facing_left(facing_left), .airborne(airborne)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_x = 128; m_y = 672; m_face = 0; m_mode = M_GROUND;
        m_en_cyc = 0; m_air_cyc = 0; m_climb = 0; m_prev_j = 1'b0;
    endfunction

    function automatic void model_step();
        bit edge_j;
        int g;
        edge_j = btn_jump && !m_prev_j;
        m_prev_j = btn_jump;
        if (!en) return;
        m_en_cyc++;
        if (m_en_cyc % MOVE == 0) begin
            if (btn_left && !btn_right) begin
                m_face = 1;
                if (m_x > XMIN) m_x--;
            end else if (btn_right && !btn_left) begin
                m_face = 0;
                if (m_x < XMAX - CW) m_x++;
            end
        end
        g = int'(ground_ypos);
        if (m_mode == M_GROUND) begin
            if (edge_j) begin
                m_mode = M_RISE; m_air_cyc = 0; m_climb = 0;
            end else if (g > m_y) begin
                m_mode = M_FALL; m_air_cyc = 0;
            end else if (g < m_y) begin
                m_y = g;
            end
        end else if (m_mode == M_RISE) begin
            m_air_cyc++;
            if (m_air_cyc % JSTEP == 0) begin
                if (m_y == 0) begin
                    m_mode = M_FALL; m_air_cyc = 0;
                end else begin
                    m_y--; m_climb++;
                    if (m_climb == JH) begin
                        m_mode = M_FALL; m_air_cyc = 0;
                    end
                end
            end
        end else begin
            if (g <= m_y) begin
                m_y = g; m_mode = M_GROUND;
            end else begin
                m_air_cyc++;
                if (m_air_cyc % JSTEP == 0) begin
                    if (m_y + 1 >= g) begin
                        m_y = g; m_mode = M_GROUND;
                    end else begin
                        m_y++;
                    end
                end
            end
        end
    endfunction

    task automatic check(input string nm, input int ex, input int ey, input int ef, input int ea);
        n_total++;
        if (xpos !== 12'(ex) || ypos !== 12'(ey) || facing_left !== 1'(ef) || airborne !== 1'(ea)) begin
            n_bad++;
            $display("FAIL %s t=%0t: got x=%0d y=%0d face=%0d air=%0d, want x=%0d y=%0d face=%0d air=%0d",
                     nm, $time, xpos, ypos, facing_left, airborne, ex, ey, ef, ea);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check("model", m_x, m_y, m_face, (m_mode != M_GROUND) ? 1 : 0);
    endtask

    task automatic do_async_reset(input string nm);
        #1 rst = 1'b1;
        #1 check(nm, 128, 672, 0, 0);
        model_reset();
        cyc();
        rst = 1'b0;
    endtask

    function automatic void add(bit e, bit l, bit r, bit j, int g, int n,
                                int ex, int ey, int ef, int ea);
        vec_t v;
        v.en = e; v.l = l; v.r = r; v.j = j; v.g = g; v.n = n;
        v.ex = ex; v.ey = ey; v.ef = ef; v.ea = ea;
        vecs.push_back(v);
    endfunction

    initial begin
        int gl[6];
        gl = '{672, 660, 700, 3, 0, 100};

        //  en l  r  j  ground  n    x    y   f  a
        add(1, 0, 1, 0, 672,  16, 132, 672, 0, 0);
        add(1, 1, 1, 0, 672,  20, 132, 672, 0, 0);
        add(1, 1, 0, 0, 672,   8, 130, 672, 1, 0);
        add(1, 0, 1, 0, 672,  16, 132, 672, 0, 0);
        add(1, 1, 0, 0, 672, 540,   0, 672, 1, 0);
        add(1, 0, 1, 0, 672,   4,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 1);
        add(1, 0, 0, 0, 672,  10,   1, 667, 0, 1);
        add(1, 0, 0, 0, 672,  10,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 1);
        add(1, 0, 0, 1, 672,  19,   1, 671, 0, 1);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,  10,   1, 672, 0, 0);
        add(1, 0, 0, 0, 672,   1,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 1);
        add(1, 0, 0, 0, 672,   3,   1, 671, 0, 1);
        add(1, 0, 0, 1, 672,   1,   1, 670, 0, 1);
        add(1, 0, 0, 0, 672,  16,   1, 672, 0, 0);
        add(1, 0, 0, 0, 672,   4,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 1);
        add(1, 0, 0, 0, 672,  15,   1, 669, 0, 1);
        add(1, 0, 0, 0, 660,   1,   1, 660, 0, 0);
        add(1, 0, 0, 0, 700,   1,   1, 660, 0, 1);
        add(1, 0, 0, 0, 700,  10,   1, 665, 0, 1);
        add(1, 0, 0, 0, 700,  70,   1, 700, 0, 0);
        add(1, 0, 0, 0, 672,   1,   1, 672, 0, 0);
        add(1, 0, 0, 1, 672,   1,   1, 672, 0, 1);
        add(1, 0, 0, 0, 672,   3,   1, 671, 0, 1);
        add(0, 1, 0, 0, 672,  30,   1, 671, 0, 1);
        add(1, 0, 0, 0, 672,   1,   1, 670, 0, 1);
        add(1, 0, 0, 0, 672,   2,   1, 669, 0, 1);

        model_reset();
        repeat (3) @(negedge clk);
        check("reset", 128, 672, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en = vecs[i].en; btn_left = vecs[i].l; btn_right = vecs[i].r;
            btn_jump = vecs[i].j; ground_ypos = 12'(vecs[i].g);
            repeat (vecs[i].n) cyc();
            check($sformatf("row%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ef, vecs[i].ea);
        end

        // Reset while still rising must take effect before the next edge.
        do_async_reset("async_rst_midrise");

        // Rising into y=0: stops at 0, falls back down to the platform.
        en = 1'b1; btn_left = 1'b0; btn_right = 1'b0; btn_jump = 1'b0;
        ground_ypos = 12'd3;
        cyc();           check("uf_snap", 128, 3, 0, 0);
        btn_jump = 1'b1;
        cyc();           check("uf_rise", 128, 3, 0, 1);
        btn_jump = 1'b0;
        repeat (6) cyc(); check("uf_top", 128, 0, 0, 1);
        repeat (2) cyc(); check("uf_hold0", 128, 0, 0, 1);
        repeat (2) cyc(); check("uf_fall1", 128, 1, 0, 1);
        repeat (4) cyc(); check("uf_land", 128, 3, 0, 0);

        for (int k = 0; k < 4000; k++) begin
            en = ($urandom_range(0, 9) != 0);
            btn_left = 1'($urandom_range(0, 1));
            btn_right = 1'($urandom_range(0, 1));
            btn_jump = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) ground_ypos = 12'(gl[$urandom_range(0, 5)]);
            if ($urandom_range(0, 699) == 0) do_async_reset("async_rst_rand");
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/donkey_move_ctl.md
Name: donkey_move_ctl

Overview:
- Per-character motion sequencer for the Donkey sprite.
- Turns debounced player buttons into sprite position updates, paced by clock-divided move and jump ticks.
- Runs a grounded/rising/falling jump state machine and follows the current platform height.
- Outputs xpos/ypos feed the sprite draw stage; platform height comes from level logic.

Parameters:
- INITIAL_XPOS, 128, x after reset (top-left of sprite)
- INITIAL_YPOS, 672, y after reset
- CHARACTER_WIDTH, 48, sprite width in pixels
- JUMP_HEIGHT, 61, pixels climbed per jump
- JUMP_STEP_CLKS, 1_400_000, clocks per vertical pixel step (rise and fall)
- MOVE_STEP_CLKS, 250_000, clocks per horizontal pixel step
- X_MIN, 0, leftmost allowed xpos
- X_MAX, 1024, right screen edge; xpos never exceeds X_MAX-CHARACTER_WIDTH

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  game running; 0 freezes motion
- btn_left  in  1  move-left request, level
- btn_right  in  1  move-right request, level
- btn_jump  in  1  jump request, rising edge used
- ground_ypos  in  12  y of sprite top when standing on the platform under it
- xpos  out  12  sprite x, registered
- ypos  out  12  sprite y, registered
- facing_left  out  1  1 after last effective left move, 0 after right
- airborne  out  1  1 in RISING or FALLING

Behaviour:
- Reset (async, rst=1):
  - xpos=INITIAL_XPOS, ypos=INITIAL_YPOS, state=GROUNDED.
  - facing_left=0, airborne=0.
  - Both tick counters=0, jump edge register=0.
- Jump edge detection:
  - btn_jump is registered every cycle, regardless of en.
  - jump_edge = btn_jump & ~btn_jump_q.
- Move tick:
  - Counter runs 0..MOVE_STEP_CLKS-1 while en=1; holds while en=0.
  - Tick pulses on the wrap cycle.
- Horizontal move, on move tick only, in any state:
  - left=1, right=0, xpos>X_MIN: xpos-1, facing_left=1.
  - right=1, left=0, xpos<X_MAX-CHARACTER_WIDTH: xpos+1, facing_left=0.
  - Both or neither pressed: no change.
  - At a limit: xpos holds, facing_left still updates.
- Jump tick:
  - Counter runs 0..JUMP_STEP_CLKS-1 only in RISING/FALLING with en=1.
  - Cleared to 0 on entry to RISING or FALLING.
  - First vertical step therefore occurs JUMP_STEP_CLKS cycles after entry.
- State GROUNDED (airborne=0):
  - jump_edge & en -> RISING, height counter cleared.
  - Else if ground_ypos > ypos (walked off edge) -> FALLING.
  - Else if ground_ypos < ypos -> ypos=ground_ypos the same cycle (snap up onto platform).
- State RISING (airborne=1):
  - Each jump tick: ypos-1, height+1.
  - On the tick making height==JUMP_HEIGHT -> FALLING.
  - If ypos==0 before a tick -> FALLING, no decrement (no underflow).
- State FALLING (airborne=1):
  - Each jump tick: if ypos+1 >= ground_ypos, then ypos=ground_ypos and -> GROUNDED; else ypos+1.
  - If ground_ypos <= ypos at any cycle -> ypos=ground_ypos, -> GROUNDED immediately (platform rose into sprite).
- jump_edge while airborne is ignored, with no queuing.
- en=0: state, positions and counters frozen; outputs hold.
- Reset asserted mid-jump returns everything to reset values immediately.
- Widths: all position arithmetic is 12-bit unsigned; counter widths derived via $clog2 of the step parameters.

Test Plan (params: MOVE_STEP_CLKS=4, JUMP_STEP_CLKS=2, JUMP_HEIGHT=5, X_MAX=180, CHARACTER_WIDTH=48, ground_ypos=672):
- Reset check: release rst, hold btn_right=1 for 16 clk -> reset values as specified; xpos steps 128,129,130,131,132 at ticks every 4 clk; facing_left=0.
- Both directions and right limit: btn_left=btn_right=1 for 20 clk -> xpos constant. Then btn_right alone from xpos=130 -> xpos stops at 132; facing_left stays 0.
- Full jump, standing: pulse btn_jump one clk -> airborne=1 next clk; ypos 671..667 every 2 clk, reaching 667 after 10 clk; then 668..672; airborne=0 at landing; total 20 clk.
- Held jump and mid-jump press: hold btn_jump high through landing -> exactly one jump. Press again mid-rise -> ignored.
- Platform changes while airborne:
  - While at ypos=669 falling, drop ground_ypos to 660 -> ypos=660, GROUNDED.
  - While GROUNDED, set ground_ypos=700 -> FALLING, ypos steps +1 per 2 clk to 700.
- en low and reset mid-jump: en=0 during RISING for 30 clk -> ypos/xpos frozen; resumes the same step sequence after en=1. Assert rst mid-rise -> xpos=128, ypos=672, airborne=0 immediately (async).
